// File: rtl/fifo_ctrl_if.sv
// Handshake and status bundle between a FIFO user and fifo_ctrl.
// The user side drives push/pop/clear; the controller drives RAM strobes,
// addresses and all status outputs.
interface fifo_ctrl_if #(
  parameter int AW = 5
) ();
  logic          push;
  logic          pop;
  logic          clear;
  logic          wren;
  logic [AW-1:0] wraddress;
  logic          rden;
  logic [AW-1:0] rdaddress;
  logic          rd_valid;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic          overflow;
  logic          underflow;

  modport master (
    output push, pop, clear,
    input  wren, wraddress, rden, rdaddress, rd_valid, count,
           full, empty, almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  push, pop, clear,
    output wren, wraddress, rden, rdaddress, rd_valid, count,
           full, empty, almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/fifo_ctrl.sv
// Circular-buffer controller for a single-clock dual-port RAM with a
// registered read port. Converts push/pop into RAM strobes and addresses and
// tracks occupancy, status flags and one-cycle error pulses.
module fifo_ctrl #(
  parameter int  mem_depth = 32,
  parameter int  afull_th  = mem_depth - 2,
  parameter int  aempty_th = 2,
  localparam int AW        = $clog2(mem_depth)
) (
  input logic        clock,
  input logic        reset_n,
  fifo_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_PARTIAL = 2'd1,
    S_FULL    = 2'd2
  } state_t;

  localparam logic [AW:0]   DEPTH_C    = (AW+1)'(mem_depth);
  localparam logic [AW:0]   AFULL_C    = (AW+1)'(afull_th);
  localparam logic [AW:0]   AEMPTY_C   = (AW+1)'(aempty_th);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [AW:0]   CNT_ZERO   = '0;

  state_t        state_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [AW:0]   count_next;
  logic          rd_valid_reg;
  logic          afull_reg;
  logic          aempty_reg;
  logic          overflow_reg;
  logic          underflow_reg;

  logic          acc_push;
  logic          acc_pop;
  logic          run;

  // A pop is only taken when data exists; a push into a full buffer is taken
  // only if a pop frees a slot in the same cycle (no fall-through when empty).
  assign run      = reset_n & ~bus.clear;
  assign acc_pop  = bus.pop & (state_reg != S_EMPTY);
  assign acc_push = bus.push & ((state_reg != S_FULL) | acc_pop);

  assign count_next = count_reg + {{AW{1'b0}}, acc_push} - {{AW{1'b0}}, acc_pop};

  assign bus.wren         = acc_push & run;
  assign bus.rden         = acc_pop & run;
  assign bus.wraddress    = wr_ptr_reg;
  assign bus.rdaddress    = rd_ptr_reg;
  assign bus.count        = count_reg;
  assign bus.empty        = (state_reg == S_EMPTY);
  assign bus.full         = (state_reg == S_FULL);
  assign bus.rd_valid     = rd_valid_reg;
  assign bus.almost_full  = afull_reg;
  assign bus.almost_empty = aempty_reg;
  assign bus.overflow     = overflow_reg;
  assign bus.underflow    = underflow_reg;

  // State machine plus all registered bookkeeping; reset and clear both flush
  // pointers/count and suppress error pulses for requests in that cycle.
  always_ff @(posedge clock) begin
    if (!reset_n || bus.clear) begin
      state_reg     <= S_EMPTY;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      rd_valid_reg  <= 1'b0;
      afull_reg     <= 1'b0;
      aempty_reg    <= 1'b1;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (acc_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (acc_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      count_reg     <= count_next;
      rd_valid_reg  <= acc_pop;
      afull_reg     <= (count_next >= AFULL_C);
      aempty_reg    <= (count_next <= AEMPTY_C);
      overflow_reg  <= bus.push & ~acc_push;
      underflow_reg <= bus.pop & ~acc_pop;
      case (state_reg)
        S_EMPTY: begin
          if (acc_push) state_reg <= S_PARTIAL;
        end
        S_PARTIAL: begin
          if (count_next == CNT_ZERO)     state_reg <= S_EMPTY;
          else if (count_next == DEPTH_C) state_reg <= S_FULL;
        end
        S_FULL: begin
          if (acc_pop && !acc_push) state_reg <= S_PARTIAL;
        end
        default: state_reg <= S_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl at depth 8 with a behavioural RAM alongside. Directed
// steps carry hand-computed expectations; accepted pushes queue their data
// and a monitor compares RAM output on every rd_valid.
module tb_fifo_ctrl;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  fifo_ctrl_if #(.AW(AW)) bus ();

  fifo_ctrl #(
    .mem_depth(DEPTH),
    .afull_th (6),
    .aempty_th(2)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  logic [15:0] mem [DEPTH];
  logic [15:0] data_out;
  logic [15:0] wdata   = 16'h0;
  logic [15:0] wdata_n = 16'hA000;
  logic [15:0] sb [$];
  int tests     = 0;
  int fails     = 0;
  int rv_seen   = 0;
  int exp_pops  = 0;

  // Behavioural dual-port RAM with registered read
  always @(posedge clock) begin
    if (bus.wren) mem[bus.wraddress] <= wdata;
    if (bus.rden) data_out <= mem[bus.rdaddress];
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every rd_valid must carry the oldest outstanding pushed word
  always @(negedge clock) begin
    if (reset_n && bus.rd_valid) begin
      rv_seen++;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL rd_data: rd_valid with no word outstanding, got %0h expected none", data_out);
      end else begin
        check("rd_data", int'(data_out), int'(sb.pop_front()));
      end
    end
  end

  task automatic step(input logic p, input logic q, input logic c,
                      input int wa, input int ra, input logic ew, input logic er,
                      input int ec, input logic ef, input logic ee,
                      input logic eaf, input logic eae, input logic eo, input logic eu);
    bus.push  = p;
    bus.pop   = q;
    bus.clear = c;
    wdata     = wdata_n;
    #1;
    check("wren", int'(bus.wren), int'(ew));
    check("rden", int'(bus.rden), int'(er));
    check("wraddress", int'(bus.wraddress), wa);
    check("rdaddress", int'(bus.rdaddress), ra);
    if (ew) sb.push_back(wdata);
    if (er) exp_pops++;
    @(posedge clock);
    #1;
    if (c || !reset_n) sb.delete();
    check("count", int'(bus.count), ec);
    check("full", int'(bus.full), int'(ef));
    check("empty", int'(bus.empty), int'(ee));
    check("almost_full", int'(bus.almost_full), int'(eaf));
    check("almost_empty", int'(bus.almost_empty), int'(eae));
    check("overflow", int'(bus.overflow), int'(eo));
    check("underflow", int'(bus.underflow), int'(eu));
    check("rd_valid", int'(bus.rd_valid), int'(er));
    $display("[TB] rst_n=%0b push=%0b pop=%0b clear=%0b wa=%0d ra=%0d -> count=%0d full=%0b empty=%0b",
             reset_n, p, q, c, wa, ra, bus.count, bus.full, bus.empty);
    wdata_n = wdata_n + 16'h1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.push  = 1'b0;
    bus.pop   = 1'b0;
    bus.clear = 1'b0;
    reset_n   = 1'b0;
    @(posedge clock);
    #1;
    // Held in reset with push and pop requested: no strobes, reset flags
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    reset_n = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);

    // Fill 8 words
    for (int i = 0; i < 8; i++)
      step(1, 0, 0, i, 0, 1, 0, i + 1, i == 7, 0, (i + 1) >= 6, (i + 1) <= 2, 0, 0);
    // 9th push overflows, then pulse drops
    step(1, 0, 0, 0, 0, 0, 0, 8, 1, 0, 1, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 8, 1, 0, 1, 0, 0, 0);

    // Drain 8 words
    for (int i = 0; i < 8; i++)
      step(0, 1, 0, 0, i, 0, 1, 7 - i, 0, i == 7, (7 - i) >= 6, (7 - i) <= 2, 0, 0);
    // 9th pop underflows, then pulse drops
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);

    // Prime to 3, stream 20 push+pop across the wrap, drain 3
    for (int i = 0; i < 3; i++)
      step(1, 0, 0, i, 0, 1, 0, i + 1, 0, 0, 0, (i + 1) <= 2, 0, 0);
    for (int i = 0; i < 20; i++)
      step(1, 1, 0, (3 + i) % 8, i % 8, 1, 1, 3, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      step(0, 1, 0, 7, (20 + i) % 8, 0, 1, 2 - i, 0, i == 2, 0, 1, 0, 0);

    // Push+pop while empty: push only, underflow raised
    step(1, 1, 0, 7, 7, 1, 0, 1, 0, 0, 0, 1, 0, 1);
    // Fill the rest
    for (int i = 0; i < 7; i++)
      step(1, 0, 0, i, 7, 1, 0, 2 + i, i == 6, 0, (2 + i) >= 6, (2 + i) <= 2, 0, 0);
    // Push+pop while full: both accepted
    step(1, 1, 0, 7, 7, 1, 1, 8, 1, 0, 1, 0, 0, 0);
    // Pop down to 5
    for (int i = 0; i < 3; i++)
      step(0, 1, 0, 0, i, 0, 1, 7 - i, 0, 0, (7 - i) >= 6, 0, 0, 0);
    // Clear with a push pending
    step(1, 0, 1, 0, 3, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    // One word through after clear
    step(1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 1, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0);
    // Clear with a pop on empty: no underflow
    step(0, 1, 1, 1, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);

    check("rd_valid_total", rv_seen, exp_pops);
    check("sb_leftover", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Synchronous FIFO controller that sequences a single-clock dual-port RAM (separate write and read ports, registered read data) as a circular buffer. It turns push/pop requests into RAM `wren`/`rden` strobes and addresses, and keeps write/read pointers, occupancy count, status flags and error pulses. The RAM instance stays outside this block; together they form the team's FIFO.

## Interface
- `mem_depth`, 32: number of RAM words; power of two, at least 4.
- `afull_th`, mem_depth-2: `almost_full` asserts when count is at or above this value.
- `aempty_th`, 2: `almost_empty` asserts when count is at or below this value.
- AW = $clog2(mem_depth) (derived): address width.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `push`  in  1  write request; data is already on the RAM `data_in`.
- `pop`  in  1  read request.
- `clear`  in  1  synchronous flush; pointers and count go to 0.
- `wren`  out  1  RAM write enable (combinational).
- `wraddress`  out  AW  RAM write address; equals `wr_ptr`.
- `rden`  out  1  RAM read enable (combinational).
- `rdaddress`  out  AW  RAM read address; equals `rd_ptr`.
- `rd_valid`  out  1  RAM `data_out` holds popped word (registered).
- `count`  out  AW+1  occupancy, 0..mem_depth.
- `full`, `empty`  out  1 each  registered status flags.
- `almost_full`, `almost_empty`  out  1 each  registered threshold flags.
- `overflow`, `underflow`  out  1 each  one-cycle registered error pulses.

## Operation
- FSM with three states: EMPTY, PARTIAL, FULL. `empty` = (state==EMPTY) and `full` = (state==FULL), both decoded from the registered state.
- Accept rules:
  - acc_pop = `pop` & !`empty`.
  - acc_push = `push` & (!`full` | acc_pop).
  - Push and pop together while FULL: both are accepted.
  - Pop while EMPTY is rejected even with a simultaneous push; there is no fall-through.
- Strobes: `wren` = acc_push and `rden` = acc_pop. Both are forced to 0 while `reset_n`=0 or `clear`=1.
- Pointers: `wr_ptr` increments on acc_push and `rd_ptr` on acc_pop, both modulo mem_depth. Wrap from mem_depth-1 to 0 needs no special handling.
- Count: next = count + acc_push - acc_pop. It never exceeds mem_depth and never goes below 0.
- State transitions, using next count n:
  - EMPTY→PARTIAL on push only.
  - PARTIAL→EMPTY when n==0.
  - PARTIAL→FULL when n==mem_depth.
  - FULL→PARTIAL on pop only.
  - Push+pop leaves the state unchanged.
  - If mem_depth were 1 a push could go EMPTY→FULL directly; this is excluded by the depth ≥4 rule.
- `almost_full` = (n ≥ afull_th) and `almost_empty` = (n ≤ aempty_th), both registered from next count.
- Errors:
  - `overflow` is registered (`push` & !acc_push).
  - `underflow` is registered (`pop` & !acc_pop).
  - A rejected request changes no pointer, count or state.
- `clear` (with `reset_n`=1): pointers, count and state go to 0/EMPTY. Any push/pop in that cycle is ignored, and no error pulse is raised for it. RAM contents are not erased.
- Reset (`reset_n`=0 at an edge) has the same effect as `clear`. It overrides everything, including a transfer in progress; the word lost in flight is not reported.

## Timing
- Reset values of registered outputs:
  - `count`=0, `empty`=1, `full`=0, `almost_empty`=1, `almost_full`=0.
  - `rd_valid`=0, `overflow`=0, `underflow`=0.
  - `wraddress`=`rdaddress`=0.
- Write: `wren`/`wraddress` are valid in the same cycle as `push`; the RAM captures the word on that edge.
- Read: `rden`/`rdaddress` are valid in the same cycle as `pop`. The RAM updates `data_out` at that edge, and `rd_valid`=1 in the following cycle only.
- Flags, `count` and error pulses reflect a request one cycle after it (after the edge that samples it).
- A word pushed at edge k can be popped by a `pop` in the cycle after edge k; its data appears one cycle later.
- Back-to-back push and/or pop every cycle is supported at full throughput.

## Test plan
- Reset, then idle: `count`=0, `empty`=1, `almost_empty`=1, `full`=0; `wren`=`rden`=0 while `reset_n`=0 even with `push`=`pop`=1.
- mem_depth=8: push 8 words with no pops → `count` steps 1..8; `almost_full` at count 6; `full`=1 after the 8th; a 9th push gives `wren`=0 and `overflow`=1 for one cycle, with `count` staying 8.
- From full, pop 8 → `rdaddress` goes 0..7; `rd_valid` pulses each cycle, one cycle late; `empty`=1 after the 8th; a 9th pop gives `rden`=0, `underflow`=1 and `count`=0.
- Wrap: push/pop 20 words streaming at count 3 → `wraddress` wraps 7→0; data out equals data in, in order; `count` holds at 3.
- Simultaneous push+pop: when FULL, both are accepted and `count` stays 8; when EMPTY, only the push is accepted, `underflow`=1 and `count`=1.
- `clear` at count 5 with `push`=1 → `wren`=0; next cycle `count`=0, `empty`=1, both pointers 0, no `overflow`.
